// File: rtl/tcp_tx_segmenter_if.sv
// Handshake interfaces for the TCP TX segmenter: a valid/ready sideband
// carrying a flat metadata word, and an AXI4-Stream data channel.
interface meta_if #(
   parameter int WIDTH = 32
) ();
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport m (output valid, data, input ready);
   modport s (input valid, data, output ready);
endinterface

interface axis_if #(
   parameter int DATA_BITS = 512
) ();
   logic                   tvalid;
   logic                   tready;
   logic [DATA_BITS-1:0]   tdata;
   logic [DATA_BITS/8-1:0] tkeep;
   logic                   tlast;

   modport m (output tvalid, tdata, tkeep, tlast, input tready);
   modport s (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/tcp_tx_segmenter.sv
// Per-region TCP transmit front-end: splits one user send into MAX_SEG segments,
// retries on "no space" with backoff. Define TCP_TX_SEG_STATS_EN for the counters.
module tcp_tx_segmenter #(
   parameter int DATA_BITS   = 512,
   parameter int MAX_SEG     = 1024,
   parameter int BACKOFF_CYC = 256,
   parameter int MAX_RETRY   = 8
) (
   input  logic        aclk,
   input  logic        aresetn,
   meta_if.s           s_req,
   meta_if.m           m_done,
   meta_if.m           m_tx_meta,
   meta_if.s           s_tx_stat,
   axis_if.s           s_axis_tx,
   axis_if.m           m_axis_tx,
   output logic [31:0] stat_segs,
   output logic [31:0] stat_retries,
   output logic [31:0] stat_drops
);
   localparam int BB     = DATA_BITS / 8;
   localparam int LOG_BB = $clog2(BB);
   localparam int RW     = $clog2(MAX_RETRY + 1);
   localparam int BW     = $clog2(BACKOFF_CYC + 1);

   typedef enum logic [2:0] {IDLE, META, STAT, BACKOFF, DATA, DROP, DONE} state_t;

   state_t          state_reg;
   logic [15:0]     sid_reg;
   logic [31:0]     rem_reg;
   logic [31:0]     sent_reg;
   logic [15:0]     seg_reg;
   logic [RW-1:0]   retry_reg;
   logic [BW-1:0]   backoff_reg;
   logic [31:0]     beats_reg;
   logic [1:0]      status_reg;
   logic            req_ready_reg;
   logic            meta_valid_reg;
   logic            stat_ready_reg;
   logic            done_valid_reg;

   function automatic logic [15:0] min_seg(input logic [31:0] r);
      return (r > 32'(MAX_SEG)) ? 16'(MAX_SEG) : r[15:0];
   endfunction

   logic        in_data, in_drop, last_beat, beat_fire, stat_fire, retry_max;
   logic [1:0]  stat_err;
   logic [31:0] rem_after;
   logic [16:0] seg_round;
   logic [32:0] rem_round;
   logic [BB-1:0] keep_last;
   logic [LOG_BB-1:0] seg_mod;

   assign in_data   = (state_reg == DATA);
   assign in_drop   = (state_reg == DROP);
   assign last_beat = (beats_reg == 32'd1);
   assign beat_fire = s_axis_tx.tvalid & s_axis_tx.tready;
   assign stat_fire = s_tx_stat.valid & stat_ready_reg;
   assign retry_max = (retry_reg == RW'(MAX_RETRY));
   assign rem_after = rem_reg - 32'(seg_reg);
   assign seg_round = {1'b0, seg_reg} + 17'(BB - 1);
   assign rem_round = {1'b0, rem_reg} + 33'(BB - 1);
   assign seg_mod   = seg_reg[LOG_BB-1:0];

   // A status that does not echo the issued segment is as bad as a closed session.
   always_comb begin
      stat_err = s_tx_stat.data[63:62];
      if (s_tx_stat.data[31:16] != seg_reg || s_tx_stat.data[15:0] != sid_reg)
         stat_err = 2'd2;
   end

   genvar gi;
   generate
      for (gi = 0; gi < BB; gi++) begin : g_keep
         assign keep_last[gi] = (seg_mod == '0) || (LOG_BB'(gi) < seg_mod);
      end
   endgenerate

   assign m_axis_tx.tvalid = in_data & s_axis_tx.tvalid;
   assign m_axis_tx.tdata  = s_axis_tx.tdata;
   assign m_axis_tx.tlast  = in_data & last_beat;
   assign m_axis_tx.tkeep  = (in_data & last_beat) ? keep_last : '1;
   assign s_axis_tx.tready = in_data ? m_axis_tx.tready : in_drop;

   assign s_req.ready     = req_ready_reg;
   assign m_tx_meta.valid = meta_valid_reg;
   assign m_tx_meta.data  = {seg_reg, sid_reg};
   assign s_tx_stat.ready = stat_ready_reg;
   assign m_done.valid    = done_valid_reg;
   assign m_done.data     = {status_reg, sent_reg, sid_reg};

   logic unused_bits;
   assign unused_bits = &{1'b0, s_axis_tx.tlast, s_axis_tx.tkeep, s_tx_stat.data[61:32]};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg      <= IDLE;
         sid_reg        <= '0;
         rem_reg        <= '0;
         sent_reg       <= '0;
         seg_reg        <= '0;
         retry_reg      <= '0;
         backoff_reg    <= '0;
         beats_reg      <= '0;
         status_reg     <= '0;
         req_ready_reg  <= 1'b1;
         meta_valid_reg <= 1'b0;
         stat_ready_reg <= 1'b0;
         done_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (s_req.valid && req_ready_reg) begin
               req_ready_reg <= 1'b0;
               sid_reg       <= s_req.data[15:0];
               rem_reg       <= s_req.data[47:16];
               seg_reg       <= min_seg(s_req.data[47:16]);
               sent_reg      <= '0;
               retry_reg     <= '0;
               status_reg    <= 2'd0;
               if (s_req.data[47:16] == 32'd0) begin
                  done_valid_reg <= 1'b1;
                  state_reg      <= DONE;
               end else begin
                  meta_valid_reg <= 1'b1;
                  state_reg      <= META;
               end
            end
            META: if (m_tx_meta.ready) begin
               meta_valid_reg <= 1'b0;
               stat_ready_reg <= 1'b1;
               state_reg      <= STAT;
            end
            STAT: if (stat_fire) begin
               stat_ready_reg <= 1'b0;
               if (stat_err == 2'd0) begin
                  retry_reg <= '0;
                  beats_reg <= 32'(seg_round[16:LOG_BB]);
                  state_reg <= DATA;
               end else if (stat_err == 2'd1 && !retry_max) begin
                  retry_reg   <= retry_reg + RW'(1);
                  backoff_reg <= BW'(BACKOFF_CYC);
                  state_reg   <= BACKOFF;
               end else begin
                  status_reg <= (stat_err == 2'd1) ? 2'd1 : 2'd2;
                  beats_reg  <= 32'(rem_round[32:LOG_BB]);
                  state_reg  <= DROP;
               end
            end
            BACKOFF: begin
               if (backoff_reg == '0) begin
                  meta_valid_reg <= 1'b1;
                  state_reg      <= META;
               end else begin
                  backoff_reg <= backoff_reg - BW'(1);
               end
            end
            DATA: if (beat_fire) begin
               beats_reg <= beats_reg - 32'd1;
               if (last_beat) begin
                  rem_reg  <= rem_after;
                  sent_reg <= sent_reg + 32'(seg_reg);
                  seg_reg  <= min_seg(rem_after);
                  if (rem_after == 32'd0) begin
                     status_reg     <= 2'd0;
                     done_valid_reg <= 1'b1;
                     state_reg      <= DONE;
                  end else begin
                     meta_valid_reg <= 1'b1;
                     state_reg      <= META;
                  end
               end
            end
            DROP: if (beat_fire) begin
               beats_reg <= beats_reg - 32'd1;
               if (last_beat) begin
                  done_valid_reg <= 1'b1;
                  state_reg      <= DONE;
               end
            end
            DONE: if (m_done.ready) begin
               done_valid_reg <= 1'b0;
               req_ready_reg  <= 1'b1;
               state_reg      <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef TCP_TX_SEG_STATS_EN
   logic [2:0] cnt_inc;
   assign cnt_inc[0] = in_data & beat_fire & last_beat;
   assign cnt_inc[1] = stat_fire & (stat_err == 2'd1) & ~retry_max;
   assign cnt_inc[2] = stat_fire & (stat_err[1] | ((stat_err == 2'd1) & retry_max));

   generate
      for (gi = 0; gi < 3; gi++) begin : g_cnt
         logic [31:0] cnt_reg;
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)
               cnt_reg <= '0;
            else if (cnt_inc[gi] && cnt_reg != '1)
               cnt_reg <= cnt_reg + 32'd1;
         end
      end
   endgenerate

   assign stat_segs    = g_cnt[0].cnt_reg;
   assign stat_retries = g_cnt[1].cnt_reg;
   assign stat_drops   = g_cnt[2].cnt_reg;
`else
   assign stat_segs    = '0;
   assign stat_retries = '0;
   assign stat_drops   = '0;
`endif
endmodule

// File: tb/tb_tcp_tx_segmenter.sv
// Directed self-checking bench for tcp_tx_segmenter (default parameters).
module tb_tcp_tx_segmenter;
   localparam int DB = 512;

`ifdef TCP_TX_SEG_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int stat_cyc = 0;
   int meta_cyc = 0;

   meta_if #(.WIDTH(48)) req_if ();
   meta_if #(.WIDTH(50)) done_if ();
   meta_if #(.WIDTH(32)) txm_if ();
   meta_if #(.WIDTH(64)) stat_if ();
   axis_if #(.DATA_BITS(DB)) in_if ();
   axis_if #(.DATA_BITS(DB)) out_if ();

   logic [31:0] stat_segs, stat_retries, stat_drops;

   tcp_tx_segmenter dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .s_req        (req_if),
      .m_done       (done_if),
      .m_tx_meta    (txm_if),
      .s_tx_stat    (stat_if),
      .s_axis_tx    (in_if),
      .m_axis_tx    (out_if),
      .stat_segs    (stat_segs),
      .stat_retries (stat_retries),
      .stat_drops   (stat_drops)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      @(negedge aclk);
   endtask

   task automatic send_req(input logic [31:0] len, input logic [15:0] sid);
      req_if.data  = {len, sid};
      req_if.valid = 1'b1;
      #1;
      check("req_ready", req_if.ready, 1'b1);
      $display("[TB] req  len=%0d sid=%h", len, sid);
      tick();
      req_if.valid = 1'b0;
   endtask

   task automatic expect_meta(input logic [15:0] len, input logic [15:0] sid);
      int n = 0;
      while (txm_if.valid !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      meta_cyc = cyc;
      check("meta_valid", txm_if.valid, 1'b1);
      check("meta_data", txm_if.data, {len, sid});
      $display("[TB] meta len=%0d sid=%h at cycle %0d", txm_if.data[31:16], txm_if.data[15:0], cyc);
      txm_if.ready = 1'b1;
      tick();
      txm_if.ready = 1'b0;
   endtask

   task automatic send_stat(input logic [1:0] err, input logic [15:0] len, input logic [15:0] sid);
      stat_if.data  = {err, 30'h100, len, sid};
      stat_if.valid = 1'b1;
      #1;
      check("stat_ready", stat_if.ready, 1'b1);
      $display("[TB] stat err=%0d len=%0d sid=%h", err, len, sid);
      tick();
      stat_cyc = cyc;
      stat_if.valid = 1'b0;
   endtask

   task automatic beats(input int n, input logic fwd, input logic seg_end, input logic [63:0] last_keep);
      for (int i = 0; i < n; i++) begin
         in_if.tdata  = {16{$urandom()}};
         in_if.tkeep  = '1;
         in_if.tlast  = 1'b0;
         in_if.tvalid = 1'b1;
         #1;
         check("in_tready", in_if.tready, 1'b1);
         check("out_tvalid", out_if.tvalid, fwd);
         if (fwd) begin
            check("out_tdata", out_if.tdata, in_if.tdata);
            check("out_tlast", out_if.tlast, seg_end && (i == n - 1));
            check("out_tkeep", out_if.tkeep, (seg_end && (i == n - 1)) ? last_keep : 64'hFFFF_FFFF_FFFF_FFFF);
         end
         tick();
      end
      in_if.tvalid = 1'b0;
      $display("[TB] data %0d beats %s", n, fwd ? "forwarded" : "dropped");
   endtask

   task automatic expect_done(input logic [1:0] status, input logic [31:0] sent, input logic [15:0] sid);
      int n = 0;
      while (done_if.valid !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      check("done_valid", done_if.valid, 1'b1);
      check("done_data", done_if.data, {status, sent, sid});
      $display("[TB] done status=%0d sent=%0d sid=%h", done_if.data[49:48], done_if.data[47:16], done_if.data[15:0]);
      done_if.ready = 1'b1;
      tick();
      done_if.ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_seen;
      req_if.valid  = 1'b0;  req_if.data  = '0;
      done_if.ready = 1'b0;
      txm_if.ready  = 1'b0;
      stat_if.valid = 1'b0;  stat_if.data = '0;
      in_if.tvalid  = 1'b0;  in_if.tdata  = '0;  in_if.tkeep = '0;  in_if.tlast = 1'b0;
      out_if.tready = 1'b1;
      aresetn = 1'b0;
      tick();
      tick();
      check("rst_req_ready", req_if.ready, 1'b1);
      check("rst_meta_valid", txm_if.valid, 1'b0);
      check("rst_done_valid", done_if.valid, 1'b0);
      check("rst_stat_ready", stat_if.ready, 1'b0);
      check("rst_in_tready", in_if.tready, 1'b0);
      check("rst_out_tvalid", out_if.tvalid, 1'b0);
      check("rst_stat_segs", stat_segs, 32'd0);
      aresetn = 1'b1;
      tick();

      // 2500 bytes -> 1024 + 1024 + 452
      send_req(32'd2500, 16'h0011);
      check("meta_latency", txm_if.valid, 1'b1);
      expect_meta(16'd1024, 16'h0011);
      send_stat(2'd0, 16'd1024, 16'h0011);
      beats(16, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      expect_meta(16'd1024, 16'h0011);
      send_stat(2'd0, 16'd1024, 16'h0011);
      beats(16, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      expect_meta(16'd452, 16'h0011);
      send_stat(2'd0, 16'd452, 16'h0011);
      beats(8, 1'b1, 1'b1, 64'h0000_0000_0000_000F);
      expect_done(2'd0, 32'd2500, 16'h0011);
      check("segs_after_t1", stat_segs, STATS ? 32'd3 : 32'd0);

      // one no-space then success
      send_req(32'd1024, 16'h0022);
      expect_meta(16'd1024, 16'h0022);
      send_stat(2'd1, 16'd1024, 16'h0022);
      expect_meta(16'd1024, 16'h0022);
      check("backoff_gap", meta_cyc - stat_cyc, 257);
      send_stat(2'd0, 16'd1024, 16'h0022);
      beats(16, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      expect_done(2'd0, 32'd1024, 16'h0022);
      check("retries_after_t2", stat_retries, STATS ? 32'd1 : 32'd0);

      // retry exhaustion on the second segment
      send_req(32'd2048, 16'h0033);
      expect_meta(16'd1024, 16'h0033);
      send_stat(2'd0, 16'd1024, 16'h0033);
      beats(16, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      expect_meta(16'd1024, 16'h0033);
      for (int k = 0; k < 9; k++) begin
         send_stat(2'd1, 16'd1024, 16'h0033);
         if (k < 8) expect_meta(16'd1024, 16'h0033);
      end
      check("no_meta_after_drop", txm_if.valid, 1'b0);
      beats(16, 1'b0, 1'b0, 64'd0);
      expect_done(2'd1, 32'd1024, 16'h0033);
      check("drops_after_t3", stat_drops, STATS ? 32'd1 : 32'd0);
      check("retries_after_t3", stat_retries, STATS ? 32'd9 : 32'd0);
      check("segs_after_t3", stat_segs, STATS ? 32'd5 : 32'd0);

      // closed connection
      send_req(32'd640, 16'h0044);
      expect_meta(16'd640, 16'h0044);
      send_stat(2'd2, 16'd640, 16'h0044);
      beats(10, 1'b0, 1'b0, 64'd0);
      check("done_after_drop", done_if.valid, 1'b1);
      expect_done(2'd2, 32'd0, 16'h0044);
      check("drops_after_t4", stat_drops, STATS ? 32'd2 : 32'd0);

      // zero-length request
      send_req(32'd0, 16'h0055);
      check("zero_done_valid", done_if.valid, 1'b1);
      check("zero_no_meta", txm_if.valid, 1'b0);
      expect_done(2'd0, 32'd0, 16'h0055);

      // status echoing the wrong sid is treated as invalid
      send_req(32'd64, 16'h0056);
      expect_meta(16'd64, 16'h0056);
      send_stat(2'd0, 16'd64, 16'h0099);
      beats(1, 1'b0, 1'b0, 64'd0);
      expect_done(2'd2, 32'd0, 16'h0056);

      // reset in the middle of a data phase
      send_req(32'd1024, 16'h0066);
      expect_meta(16'd1024, 16'h0066);
      send_stat(2'd0, 16'd1024, 16'h0066);
      beats(5, 1'b1, 1'b0, 64'd0);
      in_if.tvalid = 1'b1;
      #1;
      check("pre_rst_out_tvalid", out_if.tvalid, 1'b1);
      aresetn = 1'b0;
      #1;
      check("mid_rst_out_tvalid", out_if.tvalid, 1'b0);
      check("mid_rst_in_tready", in_if.tready, 1'b0);
      check("mid_rst_req_ready", req_if.ready, 1'b1);
      check("mid_rst_meta_valid", txm_if.valid, 1'b0);
      check("mid_rst_segs", stat_segs, 32'd0);
      tick();
      aresetn = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done_if.valid === 1'b1) done_seen++;
      end
      in_if.tvalid = 1'b0;
      check("post_rst_no_done", done_seen, 0);
      check("post_rst_req_ready", req_if.ready, 1'b1);

      // single full beat after reset
      send_req(32'd64, 16'h0077);
      expect_meta(16'd64, 16'h0077);
      send_stat(2'd0, 16'd64, 16'h0077);
      beats(1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      expect_done(2'd0, 32'd64, 16'h0077);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/tcp_tx_segmenter.md
Name: tcp_tx_segmenter

Overview:
- Per-region TCP transmit front-end. It sits directly upstream of the TCP arbiter's per-region TX user ports (s_tcp_tx_meta_user[i], s_axis_tcp_tx_user[i], m_tcp_tx_stat_user[i]), with one instance per vFPGA region.
- It accepts one user send request of arbitrary length, splits it into MAX_SEG-byte segments, and for each segment issues tx_meta and waits for tx_stat.
- It forwards segment payload only after the stack grants the segment, backs off and retries when the TX buffer is full, and reports completion.

Parameters:
- DATA_BITS, 512: AXI4S data width; beat size BB = DATA_BITS/8 bytes.
- MAX_SEG, 1024: maximum segment bytes; must be a multiple of BB.
- BACKOFF_CYC, 256: idle cycles after a "no space" status before reissuing the same segment.
- MAX_RETRY, 8: consecutive no-space retries allowed per segment before the request fails.

Ports:
- aclk, in, 1: clock.
- aresetn, in, 1: reset, asynchronous, active-low.
- s_req, metaIntf.s, 48: user request {len[47:16] bytes, sid[15:0]}.
- m_done, metaIntf.m, 50: completion {status[49:48], sent[47:16] bytes, sid[15:0]}.
- m_tx_meta, metaIntf.m, 32: segment request to arbiter {len[31:16], sid[15:0]}.
- s_tx_stat, metaIntf.s, 64: stack status {error[63:62], remaining_space[61:32], len[31:16], sid[15:0]}.
- s_axis_tx, AXI4S.s, DATA_BITS: user payload.
- m_axis_tx, AXI4S.m, DATA_BITS: segmented payload to arbiter.
- stat_segs / stat_retries / stat_drops, out, 32 each: counters (see Optional Feature).

Behaviour:
- Reset: FSM in IDLE.
  - s_req.ready=1.
  - All valid outputs are 0: m_done, m_tx_meta, m_axis_tx.
  - s_tx_stat.ready=0; s_axis_tx.ready=0.
  - rem=0, retry=0, counters=0.
  - An aresetn assertion at any point aborts the request in progress immediately. No completion is emitted.
- IDLE: s_req fire latches sid and rem=len, sets sent=0, then goes to META. A request with len=0 goes directly to DONE with status=0, sent=0.
- META:
  - Drives m_tx_meta.valid with sid and seg=min(rem,MAX_SEG).
  - Data is held stable until ready.
  - On fire, goes to STAT.
- STAT: s_tx_stat.ready=1. On fire, branches on error:
  - 0: go to DATA and reset retry.
  - 1 (no space): if retry==MAX_RETRY, go to DROP with status=1. Otherwise retry++, load the backoff counter with BACKOFF_CYC, and go to BACKOFF.
  - 2 or 3 (closed/invalid): go to DROP with status=2.
  - A stat whose sid or len mismatches the issued segment is treated as error 2.
- BACKOFF: counter decrements each cycle; at 0, return to META with the identical segment.
- DATA:
  - Passes s_axis_tx straight through to m_axis_tx combinationally: valid/ready and data pass unchanged.
  - Beat count = ceil(seg/BB).
  - tlast=1 on the final beat of the segment regardless of input tlast.
  - tkeep: all ones except on the final beat of a partial segment, where it is the low (seg mod BB) bits set.
  - On the final beat fire: rem-=seg, sent+=seg. If rem==0 go to DONE with status=0; else go to META.
- DROP:
  - s_axis_tx.ready=1 and m_axis_tx.valid=0.
  - Discards ceil(rem/BB) beats so the user stream stays aligned, then goes to DONE. sent excludes dropped bytes.
- DONE: m_done.valid=1 with {status, sent, sid} until ready, then IDLE.
- Single outstanding request; s_req.ready=1 only in IDLE.
- Widths: rem and sent are 32-bit; seg is 16-bit. No wrap is possible because sent ≤ len.
- Back-to-back requests: IDLE is entered for one cycle minimum. Latency from s_req fire to m_tx_meta.valid is 1 cycle.

Optional Feature:
- Macro TCP_TX_SEG_STATS_EN.
- Defined: stat_segs increments on each segment's final data beat, stat_retries on each BACKOFF entry, and stat_drops on each DROP entry. Counters saturate at 2^32-1 and reset to 0.
- Undefined: the three outputs are tied to 0 and no counter flops are built.

Test Plan:
- len=2500, MAX_SEG=1024, stats error=0 always -> three metas of len 1024/1024/452; 16+16+8 beats; final beat tkeep=0x000000000000000F (4 valid bytes); m_done {status 0, sent 2500}.
- len=1024, first stat error=1, second error=0 -> second meta appears exactly BACKOFF_CYC+1 cycles after the first stat; 16 beats forwarded; stat_retries=1; done status 0.
- len=2048, first segment ok, second segment error=1 nine times -> 16 beats forwarded, then 16 input beats dropped with m_axis_tx.valid=0; done {status 1, sent 1024}; stat_drops=1.
- len=640, stat error=2 -> no output beats; 10 input beats consumed; done {status 2, sent 0}.
- len=0 -> no m_tx_meta; done {status 0, sent 0} on the cycle after the s_req fire.
- Mid-DATA of a 1024-byte segment, pull aresetn low for 1 cycle -> all valids drop immediately; s_req.ready=1; no m_done is emitted.
